// File: rtl/iterative_divider.sv
// Restoring radix-2 divider: one quotient bit per clock, signed ops done on magnitudes
// with the signs fixed up afterwards. Valid/ready handshake on operands and results.
module iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] orig_q, orig_d, dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d, remo_q, remo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic             dzo_q, dzo_d, ov_q, ov_d, ir_q, ir_d;
    logic [WIDTH:0]   rem_sh, diff;

    // dvd_q doubles as the quotient: dividend bits leave at the MSB, quotient bits enter at the LSB
    assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        orig_d  = orig_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        dzo_d   = dzo_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: if (in_valid) begin
                orig_d  = dividend;
                dvd_d   = dividend;
                dvs_d   = divisor;
                sgn_d   = is_signed;
                state_d = PREP;
            end
            PREP: begin
                qneg_d = 1'b0;
                rneg_d = 1'b0;
                if (sgn_q) begin
                    if (dvd_q[WIDTH-1]) dvd_d = -dvd_q;
                    if (dvs_q[WIDTH-1]) dvs_d = -dvs_q;
                    qneg_d = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
                    rneg_d = dvd_q[WIDTH-1];
                end
                rem_d   = '0;
                cnt_d   = CW'(WIDTH - 1);
                dz_d    = (dvs_q == '0);
                // Zero divisor still passes through FIX so every result is loaded in one place
                state_d = (dvs_q == '0) ? FIX : CALC;
            end
            CALC: begin
                dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
                rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                quo_d   = dz_q ? '1     : (qneg_q ? -dvd_q : dvd_q);
                remo_d  = dz_q ? orig_q : (rneg_q ? -rem_q : rem_q);
                dzo_d   = dz_q;
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: if (out_ready) begin
                ov_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ir_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            orig_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            dzo_q   <= 1'b0;
            ov_q    <= 1'b0;
            ir_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            orig_q  <= orig_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            dzo_q   <= dzo_d;
            ov_q    <= ov_d;
            ir_q    <= ir_d;
        end
    end

    assign in_ready    = ir_q;
    assign out_valid   = ov_q;
    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dzo_q;
endmodule

// File: tb/tb_iterative_divider.sv
// Directed and random checks of iterative_divider against a plain-arithmetic model.
module tb_iterative_divider;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, is_signed = 1'b0;
    logic [31:0] dividend = '0, divisor = '0, quotient, remainder;
    logic        out_valid, out_ready = 1'b0, div_by_zero;
    int          errors = 0, checks = 0;

    iterative_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Truncating division done with 64-bit host arithmetic
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb, sq, sr;
        dz = (b == 0);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
    endtask

    task automatic wait_result(input int exp_lat);
        int cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", cyc, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic [31:0] a,
                                input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        logic dz;
        model(a, b, s, q, r, dz);
        chk({tag, "_q"}, quotient, q);
        chk({tag, "_r"}, remainder, r);
        chk({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, dz});
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("ov_clear", {31'b0, out_valid}, 32'd0);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s);
        start(a, b, s);
        wait_result(b == 0 ? 2 : 34);
        check_result(tag, a, b, s);
        take();
    endtask

    initial begin
        logic [31:0] hq, hr, ra, rb;
        logic        hdz;
        #12;
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_ov", {31'b0, out_valid}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        rst_n = 1'b1;

        run("u100_7", 32'd100, 32'd7, 1'b0);
        chk("u100_7_qval", quotient, 32'd14);
        run("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("s_m7_2_qval", quotient, 32'hFFFF_FFFD);
        chk("s_m7_2_rval", remainder, 32'hFFFF_FFFF);
        run("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("u_m7_2_qval", quotient, 32'h7FFF_FFFC);
        run("dz_u", 32'd5, 32'd0, 1'b0);
        chk("dz_u_rval", remainder, 32'd5);
        run("dz_s", 32'd5, 32'd0, 1'b1);
        run("dz_neg", 32'hFFFF_FFF0, 32'd0, 1'b1);
        run("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("ovf_qval", quotient, 32'h8000_0000);
        chk("ovf_rval", remainder, 32'd0);
        run("u_big", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run("s_negdvs", 32'd7, 32'hFFFF_FFFE, 1'b1);

        // Backpressure: result must hold while new operands are offered and ignored
        start(32'd77, 32'd5, 1'b0);
        wait_result(34);
        hq = quotient;
        hr = remainder;
        hdz = div_by_zero;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clk);
            #1;
            chk("bp_ov", {31'b0, out_valid}, 32'd1);
            chk("bp_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_q", quotient, hq);
            chk("bp_r", remainder, hr);
            chk("bp_dz", {31'b0, div_by_zero}, {31'b0, hdz});
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_q77", hq, 32'd15);
        take();
        chk("hold_q", quotient, 32'd15);
        run("u50_5", 32'd50, 32'd5, 1'b0);
        chk("u50_5_qval", quotient, 32'd10);

        // Reset asynchronously in the middle of iterating
        start(32'd1000, 32'd3, 1'b0);
        repeat (11) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_ov", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_q", quotient, 32'd0);
        chk("mid_rst_r", remainder, 32'd0);
        chk("mid_rst_dz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("u9_4", 32'd9, 32'd4, 1'b0);
        chk("u9_4_qval", quotient, 32'd2);
        chk("u9_4_rval", remainder, 32'd1);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = rb >> $urandom_range(16, 31);
                2: rb = -(rb >> $urandom_range(20, 31));
                3: ra = ra >> $urandom_range(0, 31);
                default: ;
            endcase
            run("rand", ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
